// File: rtl/m_ctrl.sv
// Multicycle MIPS control unit: Moore FSM decoding datapath controls from the current state.
// Outputs are combinational from state (IF strobes gated by MIO_ready); memory states stall on MIO_ready.
module m_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst_in,
  input  logic        zero,
  input  logic        overflow,
  input  logic        MIO_ready,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [2:0]  ALU_operation,
  output logic [4:0]  state_out,
  output logic        CPU_MIO,
  output logic        IorD,
  output logic        IRWrite,
  output logic [1:0]  RegDst,
  output logic        RegWrite,
  output logic [1:0]  MemtoReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Branch
);

  typedef enum logic [4:0] {
    S_IF     = 5'd0,  S_ID     = 5'd1,  S_EX_R   = 5'd2,  S_EX_MEM = 5'd3,
    S_EX_I   = 5'd4,  S_LUI_WB = 5'd5,  S_EX_BEQ = 5'd6,  S_EX_BNE = 5'd7,
    S_EX_JR  = 5'd8,  S_EX_JAL = 5'd9,  S_EX_J   = 5'd10, S_MEM_RD = 5'd11,
    S_MEM_WR = 5'd12, S_WB_R   = 5'd13, S_WB_I   = 5'd14, S_WB_LW  = 5'd15,
    S_ERROR  = 5'd31
  } state_t;

  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_ADD = 3'b010,
                         ALU_SUB = 3'b110, ALU_SLT = 3'b111, ALU_NOR = 3'b100,
                         ALU_SRL = 3'b101, ALU_XOR = 3'b011;

  state_t     state_q, state_d;
  logic       ovf_q, ovf_d;
  logic [5:0] op, funct;
  logic       r_valid, ovf_trap;
  logic [2:0] r_alu, i_alu;
  logic       unused_bits;

  assign op          = Inst_in[31:26];
  assign funct       = Inst_in[5:0];
  assign state_out   = state_q;
  // Branch resolution happens in the datapath; these inputs are not needed here.
  assign unused_bits = ^{zero, Inst_in[25:6]};

  always_comb begin
    r_valid = 1'b1;
    r_alu   = ALU_ADD;
    case (funct)
      6'b100000: r_alu = ALU_ADD;
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b100110: r_alu = ALU_XOR;
      6'b100111: r_alu = ALU_NOR;
      6'b101010: r_alu = ALU_SLT;
      6'b000010: r_alu = ALU_SRL;
      default:   r_valid = 1'b0;
    endcase
    i_alu = ALU_ADD;
    case (op)
      6'b001100: i_alu = ALU_AND;
      6'b001101: i_alu = ALU_OR;
      6'b001110: i_alu = ALU_XOR;
      6'b001010: i_alu = ALU_SLT;
      default:   i_alu = ALU_ADD;
    endcase
    // Only the trapping arithmetic forms suppress writeback on overflow.
    ovf_trap = ovf_q && ((op == 6'b000000 && (funct == 6'b100000 || funct == 6'b100010))
                         || op == 6'b001000);
  end

  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IF: begin
        ovf_d = 1'b0;
        if (MIO_ready) state_d = S_ID;
      end
      S_ID: begin
        case (op)
          6'b000000: begin
            if (funct == 6'b001000) state_d = S_EX_JR;
            else if (r_valid)       state_d = S_EX_R;
            else                    state_d = S_ERROR;
          end
          6'b100011, 6'b101011:                         state_d = S_EX_MEM;
          6'b001000, 6'b001100, 6'b001101, 6'b001110,
          6'b001010:                                    state_d = S_EX_I;
          6'b001111:                                    state_d = S_LUI_WB;
          6'b000100:                                    state_d = S_EX_BEQ;
          6'b000101:                                    state_d = S_EX_BNE;
          6'b000010:                                    state_d = S_EX_J;
          6'b000011:                                    state_d = S_EX_JAL;
          default:                                      state_d = S_ERROR;
        endcase
      end
      S_EX_R:   begin ovf_d = overflow; state_d = S_WB_R; end
      S_EX_I:   begin ovf_d = overflow; state_d = S_WB_I; end
      S_EX_MEM: state_d = (op == 6'b100011) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (MIO_ready) state_d = S_WB_LW;
      S_MEM_WR: if (MIO_ready) state_d = S_IF;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_IF;
    endcase
  end

  always_comb begin
    MemRead = 1'b0; MemWrite = 1'b0; ALU_operation = 3'b000; CPU_MIO = 1'b0;
    IorD = 1'b0; IRWrite = 1'b0; RegDst = 2'b00; RegWrite = 1'b0; MemtoReg = 2'b00;
    ALUSrcA = 1'b0; ALUSrcB = 2'b00; PCSource = 2'b00; PCWrite = 1'b0;
    PCWriteCond = 1'b0; Branch = 1'b0;
    // Outputs are forced low asynchronously while reset is held.
    if (reset) begin
      case (state_q)
        S_IF: begin
          MemRead = 1'b1; CPU_MIO = 1'b1; ALUSrcB = 2'b01; ALU_operation = ALU_ADD;
          IRWrite = MIO_ready; PCWrite = MIO_ready;
        end
        S_ID:     begin ALUSrcB = 2'b11; ALU_operation = ALU_ADD; end
        S_EX_R:   begin ALUSrcA = 1'b1; ALUSrcB = 2'b00; ALU_operation = r_alu; end
        S_EX_I:   begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALU_operation = i_alu; end
        S_EX_MEM: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALU_operation = ALU_ADD; end
        S_MEM_RD: begin MemRead = 1'b1; IorD = 1'b1; CPU_MIO = 1'b1; end
        S_MEM_WR: begin MemWrite = 1'b1; IorD = 1'b1; CPU_MIO = 1'b1; end
        S_WB_R:   begin RegDst = 2'b01; RegWrite = !ovf_trap; end
        S_WB_I:   begin RegDst = 2'b00; RegWrite = !ovf_trap; end
        S_WB_LW:  begin MemtoReg = 2'b01; RegWrite = 1'b1; end
        S_LUI_WB: begin MemtoReg = 2'b10; RegWrite = 1'b1; end
        S_EX_BEQ, S_EX_BNE: begin
          ALUSrcA = 1'b1; ALU_operation = ALU_SUB; PCSource = 2'b01;
          PCWriteCond = 1'b1; Branch = (state_q == S_EX_BEQ);
        end
        S_EX_J:   begin PCSource = 2'b10; PCWrite = 1'b1; end
        S_EX_JR:  begin PCSource = 2'b11; PCWrite = 1'b1; end
        S_EX_JAL: begin
          PCSource = 2'b10; PCWrite = 1'b1; RegDst = 2'b10; MemtoReg = 2'b11; RegWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IF;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_m_ctrl.sv
// Directed-vector bench for the multicycle control FSM.
module tb_m_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Inst_in = 32'h0;
  logic        zero = 1'b0, overflow = 1'b0, MIO_ready = 1'b0;
  logic        MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, ALUSrcA;
  logic        PCWrite, PCWriteCond, Branch;
  logic [2:0]  ALU_operation;
  logic [4:0]  state_out;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
  logic [20:0] all_out;
  int          vecs = 0;
  int          errs = 0;

  m_ctrl dut (
    .clk(clk), .reset(reset), .Inst_in(Inst_in), .zero(zero), .overflow(overflow),
    .MIO_ready(MIO_ready), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALU_operation(ALU_operation), .state_out(state_out), .CPU_MIO(CPU_MIO),
    .IorD(IorD), .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch)
  );

  always #50 clk = ~clk;

  assign all_out = {MemRead, MemWrite, ALU_operation, CPU_MIO, IorD, IRWrite, RegDst,
                    RegWrite, MemtoReg, ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, Branch};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #10;
  endtask

  task automatic go(input string tag, input logic [4:0] exp_state);
    step();
    chk(tag, {27'd0, state_out}, {27'd0, exp_state});
  endtask

  initial begin
    // Reset held for 5 cycles
    repeat (5) step();
    chk("rst_state", {27'd0, state_out}, 32'd0);
    chk("rst_outs", {11'd0, all_out}, 32'd0);

    // Fetch stall then fetch
    reset = 1'b1;
    #1;
    chk("if_memread", {31'd0, MemRead}, 32'd1);
    chk("if_cpumio", {31'd0, CPU_MIO}, 32'd1);
    chk("if_alusrcb", {30'd0, ALUSrcB}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("if_hold", {27'd0, state_out}, 32'd0);
      chk("if_irwrite0", {31'd0, IRWrite}, 32'd0);
    end
    MIO_ready = 1'b1;
    #1;
    chk("if_irwrite1", {31'd0, IRWrite}, 32'd1);
    chk("if_pcwrite1", {31'd0, PCWrite}, 32'd1);
    Inst_in = 32'h00221820;
    go("add_id", 5'd1);
    chk("id_alusrcb", {30'd0, ALUSrcB}, 32'd3);
    go("add_ex", 5'd2);
    chk("add_alu", {29'd0, ALU_operation}, 32'b010);
    chk("add_srca", {31'd0, ALUSrcA}, 32'd1);
    go("add_wb", 5'd13);
    chk("add_regwrite", {31'd0, RegWrite}, 32'd1);
    chk("add_regdst", {30'd0, RegDst}, 32'd1);
    go("add_if", 5'd0);

    // add with overflow suppresses writeback
    go("addo_id", 5'd1);
    go("addo_ex", 5'd2);
    overflow = 1'b1;
    go("addo_wb", 5'd13);
    overflow = 1'b0;
    chk("addo_regwrite", {31'd0, RegWrite}, 32'd0);
    go("addo_if", 5'd0);

    // or with overflow still writes back
    Inst_in = 32'h00221825;
    go("or_id", 5'd1);
    go("or_ex", 5'd2);
    chk("or_alu", {29'd0, ALU_operation}, 32'b001);
    overflow = 1'b1;
    go("or_wb", 5'd13);
    overflow = 1'b0;
    chk("or_regwrite", {31'd0, RegWrite}, 32'd1);
    go("or_if", 5'd0);

    // srl
    Inst_in = 32'h00011042;
    go("srl_id", 5'd1);
    go("srl_ex", 5'd2);
    chk("srl_alu", {29'd0, ALU_operation}, 32'b101);
    go("srl_wb", 5'd13);
    go("srl_if", 5'd0);

    // addi with overflow
    Inst_in = 32'h20220004;
    go("addi_id", 5'd1);
    go("addi_ex", 5'd4);
    chk("addi_alu", {29'd0, ALU_operation}, 32'b010);
    chk("addi_srcb", {30'd0, ALUSrcB}, 32'd2);
    overflow = 1'b1;
    go("addi_wb", 5'd14);
    overflow = 1'b0;
    chk("addi_regwrite", {31'd0, RegWrite}, 32'd0);
    go("addi_if", 5'd0);

    // lw with two memory wait cycles
    Inst_in = 32'h8C220004;
    go("lw_id", 5'd1);
    go("lw_ex", 5'd3);
    chk("lw_ex_srcb", {30'd0, ALUSrcB}, 32'd2);
    go("lw_mem", 5'd11);
    MIO_ready = 1'b0;
    chk("lw_mem_ctl", {29'd0, MemRead, IorD, CPU_MIO}, 32'b111);
    go("lw_wait1", 5'd11);
    go("lw_wait2", 5'd11);
    MIO_ready = 1'b1;
    go("lw_wb", 5'd15);
    chk("lw_memtoreg", {30'd0, MemtoReg}, 32'd1);
    chk("lw_regwrite", {31'd0, RegWrite}, 32'd1);
    go("lw_if", 5'd0);

    // sw
    Inst_in = 32'hAC220004;
    go("sw_id", 5'd1);
    go("sw_ex", 5'd3);
    go("sw_mem", 5'd12);
    chk("sw_ctl", {29'd0, MemWrite, IorD, CPU_MIO}, 32'b111);
    go("sw_if", 5'd0);

    // beq / bne
    Inst_in = 32'h10220003;
    go("beq_id", 5'd1);
    go("beq_ex", 5'd6);
    chk("beq_ctl", {25'd0, ALU_operation, PCSource, PCWriteCond, Branch}, {25'd0, 3'b110, 2'b01, 1'b1, 1'b1});
    go("beq_if", 5'd0);
    Inst_in = 32'h14220003;
    go("bne_id", 5'd1);
    go("bne_ex", 5'd7);
    chk("bne_ctl", {25'd0, ALU_operation, PCSource, PCWriteCond, Branch}, {25'd0, 3'b110, 2'b01, 1'b1, 1'b0});
    go("bne_if", 5'd0);

    // jumps and lui
    Inst_in = 32'h0C000010;
    go("jal_id", 5'd1);
    go("jal_ex", 5'd9);
    chk("jal_ctl", {24'd0, RegDst, MemtoReg, RegWrite, PCSource, PCWrite}, {24'd0, 2'b10, 2'b11, 1'b1, 2'b10, 1'b1});
    go("jal_if", 5'd0);
    Inst_in = 32'h08000010;
    go("j_id", 5'd1);
    go("j_ex", 5'd10);
    chk("j_ctl", {29'd0, PCSource, PCWrite}, {29'd0, 2'b10, 1'b1});
    go("j_if", 5'd0);
    Inst_in = 32'h03E00008;
    go("jr_id", 5'd1);
    go("jr_ex", 5'd8);
    chk("jr_ctl", {29'd0, PCSource, PCWrite}, {29'd0, 2'b11, 1'b1});
    go("jr_if", 5'd0);
    Inst_in = 32'h3C011234;
    go("lui_id", 5'd1);
    go("lui_wb", 5'd5);
    chk("lui_ctl", {28'd0, RegDst, MemtoReg, RegWrite}, {28'd0, 2'b00, 2'b10, 1'b1});
    go("lui_if", 5'd0);

    // reset aborts a stalled store
    Inst_in = 32'hAC220004;
    go("swr_id", 5'd1);
    go("swr_ex", 5'd3);
    go("swr_mem", 5'd12);
    MIO_ready = 1'b0;
    #20;
    reset = 1'b0;
    #1;
    chk("swr_rst_state", {27'd0, state_out}, 32'd0);
    chk("swr_rst_outs", {11'd0, all_out}, 32'd0);
    step();
    reset = 1'b1;
    MIO_ready = 1'b1;
    go("swr_refetch", 5'd1);

    // illegal opcode locks in ERROR
    Inst_in = 32'h00000000;
    go("err_enter", 5'd31);
    chk("err_outs", {11'd0, all_out}, 32'd0);
    go("err_hold1", 5'd31);
    go("err_hold2", 5'd31);
    #20;
    reset = 1'b0;
    #1;
    chk("err_rst", {27'd0, state_out}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
